// File: rtl/remote_cmd_rx.sv
// remote_cmd_rx: device-side end of the remote command link.
// Reassembles a 16-bit command from two serial bytes (high byte first),
// discards a half-received pair after an inter-byte timeout, and sends
// single response bytes back to the remote on request.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   RX / TX      serial lines from / to the remote (8N1)
//   cmd          assembled command {high_byte, low_byte}
//   cmd_rdy      command valid; held until clr_cmd_rdy or a new pair starts
//   clr_cmd_rdy  consumer acknowledge (a set in the same cycle wins)
//   sync_err     one-cycle pulse when a byte pair times out
//   resp         response byte to send
//   send_resp    one-cycle request to transmit resp
//   resp_busy    response transmission in progress
//   resp_sent    last response fully shifted out
//
// TIMEOUT_CYCLES must lie in [2, 2**20]. BAUD_DIV is clk cycles per bit
// and must be at least 4.
module remote_cmd_rx #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int BAUD_DIV       = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        sync_err,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_busy,
  output logic        resp_sent
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {WAIT_HI, WAIT_LO} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_BUSY} tx_state_t;

  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       clr_rx_rdy;
  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done;

  assign rst_n = ~rst;

  UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .TX        (TX),
    .rx_rdy    (rx_rdy),
    .clr_rx_rdy(clr_rx_rdy),
    .rx_data   (rx_data),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .tx_done   (tx_done)
  );

  // ---------------- receive framing ----------------
  rx_state_t   rx_state, rx_state_next;
  logic [7:0]  hi_byte, hi_byte_next;
  logic [TW-1:0] timer, timer_next;
  logic [15:0] cmd_next;
  logic        cmd_rdy_next;
  logic        sync_err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= WAIT_HI;
      hi_byte  <= 8'h00;
      timer    <= '0;
      cmd      <= 16'h0000;
      cmd_rdy  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      rx_state <= rx_state_next;
      hi_byte  <= hi_byte_next;
      timer    <= timer_next;
      cmd      <= cmd_next;
      cmd_rdy  <= cmd_rdy_next;
      sync_err <= sync_err_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state;
    hi_byte_next  = hi_byte;
    timer_next    = timer;
    cmd_next      = cmd;
    // Clear first; any set below overrides it so a completion wins.
    cmd_rdy_next  = clr_cmd_rdy ? 1'b0 : cmd_rdy;
    sync_err_next = 1'b0;
    clr_rx_rdy    = 1'b0;
    case (rx_state)
      WAIT_HI: begin
        if (rx_rdy) begin
          hi_byte_next  = rx_data;
          clr_rx_rdy    = 1'b1;
          cmd_rdy_next  = 1'b0;
          timer_next    = '0;
          rx_state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        timer_next = timer + TW'(1);
        // The low byte is checked before the timeout so a byte arriving
        // on the last allowed cycle still completes the command.
        if (rx_rdy) begin
          cmd_next      = {hi_byte, rx_data};
          cmd_rdy_next  = 1'b1;
          clr_rx_rdy    = 1'b1;
          rx_state_next = WAIT_HI;
        end else if (timer == TIMER_LAST) begin
          sync_err_next = 1'b1;
          hi_byte_next  = 8'h00;
          rx_state_next = WAIT_HI;
        end
      end
      default: rx_state_next = WAIT_HI;
    endcase
  end

  // ---------------- response transmit ----------------
  tx_state_t  tx_state, tx_state_next;
  logic [7:0] resp_reg, resp_reg_next;
  logic       resp_sent_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= T_IDLE;
      resp_reg  <= 8'h00;
      resp_sent <= 1'b0;
    end else begin
      tx_state  <= tx_state_next;
      resp_reg  <= resp_reg_next;
      resp_sent <= resp_sent_next;
    end
  end

  always_comb begin
    tx_state_next  = tx_state;
    resp_reg_next  = resp_reg;
    resp_sent_next = resp_sent;
    trmt           = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (send_resp) begin
          resp_reg_next  = resp;
          resp_sent_next = 1'b0;
          tx_state_next  = T_LOAD;
        end
      end
      T_LOAD: begin
        trmt          = 1'b1;
        tx_state_next = T_BUSY;
      end
      T_BUSY: begin
        if (tx_done) begin
          resp_sent_next = 1'b1;
          tx_state_next  = T_IDLE;
        end
      end
      default: tx_state_next = T_IDLE;
    endcase
  end

  assign tx_data   = resp_reg;
  assign resp_busy = (tx_state != T_IDLE);

endmodule

// UART: 8N1 transceiver, BAUD_DIV clk cycles per bit.
//   rx_rdy   set when a byte has been received, cleared by clr_rx_rdy
//   rx_data  last received byte
//   trmt     one-cycle request to send tx_data
//   tx_done  one-cycle pulse at the end of the stop bit
module UART #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] B_LAST = BW'(BAUD_DIV - 1);
  // Two cycles of synchroniser lag are absorbed by sampling slightly
  // before the nominal half-bit point.
  localparam logic [BW-1:0] B_HALF = BW'(BAUD_DIV / 2 - 1);

  logic          rx_meta, rx_s;
  logic          rx_busy;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bits;
  logic [7:0]    rx_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  // Sample index 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy <= 1'b0;
      rx_baud <= '0;
      rx_bits <= 4'd0;
      rx_sh   <= 8'h00;
      rx_data <= 8'h00;
      rx_rdy  <= 1'b0;
    end else begin
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s) begin
          rx_busy <= 1'b1;
          rx_baud <= B_HALF;
          rx_bits <= 4'd0;
        end
      end else if (rx_baud != '0) begin
        rx_baud <= rx_baud - BW'(1);
      end else begin
        rx_baud <= B_LAST;
        if (rx_bits == 4'd9) begin
          rx_busy <= 1'b0;
          rx_data <= rx_sh;
          rx_rdy  <= 1'b1;
        end else begin
          rx_bits <= rx_bits + 4'd1;
          if (rx_bits != 4'd0) rx_sh <= {rx_s, rx_sh[7:1]};
        end
      end
    end
  end

  logic [9:0]    tx_sh;
  logic          tx_busy;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bits;

  // Frame is {stop, data, start}; shifting in ones leaves the line idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh   <= '1;
      tx_busy <= 1'b0;
      tx_baud <= '0;
      tx_bits <= 4'd0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt) begin
        tx_sh   <= {1'b1, tx_data, 1'b0};
        tx_busy <= 1'b1;
        tx_baud <= '0;
        tx_bits <= 4'd0;
      end else if (tx_busy) begin
        if (tx_baud == B_LAST) begin
          tx_baud <= '0;
          tx_sh   <= {1'b1, tx_sh[9:1]};
          if (tx_bits == 4'd9) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            tx_bits <= tx_bits + 4'd1;
          end
        end else begin
          tx_baud <= tx_baud + BW'(1);
        end
      end
    end
  end

  assign TX = tx_sh[0];

endmodule
